// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared constants and FSM encoding for the UART transmitter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int   CLK_FREQ_DEFAULT = 50_000_000;
  localparam int   BAUD_DEFAULT     = 9600;
  localparam int   DATA_BITS        = 8;
  localparam logic IDLE_LEVEL       = 1'b1;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, one-cycle bit_end tick per bit       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int             CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign bit_end = enable && !clear && (r_count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_serializer : 8N1 UART transmitter, LSB first, busy/done status   |
// | Option macro UART_TX_PARITY_EN adds an even parity bit (8E1).            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int BAUD     = BAUD_DEFAULT,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 UART_TX
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_bit_end;

  assign w_accept = (r_state == ST_IDLE) && tx_start;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .enable  (r_state != ST_IDLE),
    .bit_end (w_bit_end)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte at accept time; the shift register is consumed.
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= even_parity(tx_data);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_start) begin
            r_state   <= ST_START;
            r_shift   <= tx_data;
            r_bit_idx <= '0;
            r_tx      <= ~IDLE_LEVEL;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= IDLE_LEVEL;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign UART_TX = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_tx_serializer : randomized scoreboard bench for the UART transmitter.
// Define UART_TX_PARITY_EN for both RTL and bench to cover the 11-bit frame.
module tb_uart_tx_serializer;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int B        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * B;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int model_left = 0;

  logic [NB-1:0] exp_q[$];
  int            exp_t[$];

  uart_tx_serializer #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .UART_TX  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Line image of one frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (NB == 11) f[9] = (($countones(d) % 2) == 1);
    return f;
  endfunction

  // Reference model: a request is taken whenever the previous frame plus one idle cycle has elapsed.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_left = 0;
      exp_q.delete();
      exp_t.delete();
    end else begin
      cyc++;
      if (model_left > 0) begin
        model_left--;
      end else if (tx_start) begin
        exp_q.push_back(frame_of(tx_data));
        exp_t.push_back(cyc);
        model_left = FRAME;
      end
    end
  end

  initial begin : monitor
    logic [NB-1:0] got;
    logic [NB-1:0] exp_f;
    int            start_cyc;
    int            busy_cnt;
    int            done_in;
    bit            aborted;
    forever begin
      @(negedge clk);
      if (reset && uart_tx === 1'b0) begin
        got = '0; busy_cnt = 0; done_in = 0; aborted = 0;
        start_cyc = cyc;
        for (int c = 0; c < FRAME; c++) begin
          if (!reset) begin aborted = 1; break; end
          if (c % B == B / 2) got[c/B] = uart_tx;
          if (tx_busy === 1'b1) busy_cnt++;
          if (tx_done !== 1'b0) done_in++;
          @(negedge clk);
        end
        if (!aborted && reset) begin
          check("done_pulse", {31'd0, tx_done}, 32'd1);
          check("busy_after", {31'd0, tx_busy}, 32'd0);
          check("line_after", {31'd0, uart_tx}, 32'd1);
          check("busy_len", busy_cnt, FRAME);
          check("done_during", done_in, 0);
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_frame: got %0h, required no frame", got);
          end else begin
            exp_f = exp_q.pop_front();
            check("frame_bits", got, exp_f);
            check("start_cycle", start_cyc, exp_t.pop_front());
          end
        end
      end
    end
  end

  initial begin : done_watch
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_done !== 1'b0) check("done_width", {31'd0, tx_done}, 32'd0);
      prev = tx_done;
    end
  end

  task automatic send(input logic [7:0] d, input int hold);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    repeat (hold) @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((model_left != 0 || tx_busy !== 1'b0) && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FRAME) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_idle", {29'd0, uart_tx, tx_busy, tx_done}, 32'b100);
    end

    send(8'h5A, 1);
    wait_idle();

    // Second request with other data mid-frame must be ignored.
    send(8'h00, 1);
    repeat (34) @(negedge clk);
    tx_data = 8'hFF; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();

    send(8'hA5, FRAME + 2);
    wait_idle();

    send(8'h07, 1);
    wait_idle();
    send(8'hFF, 1);
    wait_idle();

    for (int it = 0; it < 30; it++) begin
      send(8'($urandom), $urandom_range(1, 3));
      for (int k = 0; k < int'($urandom_range(1, FRAME + 20)); k++) begin
        @(negedge clk);
        tx_data  = 8'($urandom);
        tx_start = ($urandom_range(0, 49) == 0);
      end
      tx_start = 1'b0;
    end
    wait_idle();

    // Reset during data bit 3, then a clean frame.
    send(8'hC3, 1);
    repeat (4 * B + 3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("reset_async", {29'd0, uart_tx, tx_busy, tx_done}, 32'b100);
    @(negedge clk);
    check("reset_hold", {29'd0, uart_tx, tx_busy, tx_done}, 32'b100);
    #2 reset = 1'b1;
    send(8'h0F, 1);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
